hpdmc_ctlif_v2: RTL

HPDMC_CTLIF_V2 -- requirements
Module: hpdmc_ctlif_v2

---
 rtl/hpdmc_ctlif_v2_if.sv | 10 +
 rtl/hpdmc_ctlif_v2.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_ctlif_v2_if.sv
// CSR bus between the system-side master and the HPDMC control interface.
interface hpdmc_ctlif_v2_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, csr_we, csr_di, input csr_do);
  modport slave  (input csr_a, csr_we, csr_di, output csr_do);
endinterface

// File: rtl/hpdmc_ctlif_v2.sv
// HPDMC control interface: SDRAM pin control, timing registers, IDELAY lane
// taps and DQS phase-shift sequencing behind a small CSR bank.
//
// PS FSM states:
//   state   | meaning
//   PS_IDLE | no shift outstanding; a start request pulses dqs_psen
//   PS_WAIT | waiting for dqs_psdone, bounded by the timeout down-counter
module hpdmc_ctlif_v2 #(
  parameter logic [3:0] CSR_ADDR   = 4'h0,
  parameter int         ADR_W      = 13,
  parameter int         BA_W       = 2,
  parameter int         LANES      = 2,
  parameter int         TAP_W      = 6,
  parameter int         PS_TIMEOUT = 255
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  hpdmc_ctlif_v2_if.slave    csr,
  output logic               bypass,
  output logic               sdram_rst,
  output logic               sdram_cke,
  output logic               sdram_cs_n,
  output logic               sdram_we_n,
  output logic               sdram_cas_n,
  output logic               sdram_ras_n,
  output logic [ADR_W-1:0]   sdram_adr,
  output logic [BA_W-1:0]    sdram_ba,
  output logic [2:0]         tim_rp,
  output logic [2:0]         tim_rcd,
  output logic               tim_cas,
  output logic [10:0]        tim_refi,
  output logic [3:0]         tim_rfc,
  output logic [1:0]         tim_wr,
  output logic [LANES-1:0]   idelay_rst,
  output logic [LANES-1:0]   idelay_ce,
  output logic [LANES-1:0]   idelay_inc,
  output logic               dqs_psen,
  output logic               dqs_psincdec,
  input  logic               dqs_psdone,
  input  logic [1:0]         pll_stat
);

  localparam int TMR_W = (PS_TIMEOUT > 1) ? $clog2(PS_TIMEOUT + 1) : 1;

  typedef enum logic {PS_IDLE, PS_WAIT} ps_state_t;

  ps_state_t          ps_state;
  logic [TMR_W-1:0]   ps_tmr;
  logic               ps_dir;
  logic signed [9:0]  ps_pos;
  logic               ps_err;
  logic               ps_ovr;
  logic [1:0]         pll_meta;
  logic [1:0]         pll_sync;
  logic [TAP_W-1:0]   tap [LANES];

  logic        sel;
  logic [2:0]  reg_sel;
  logic        wr0, wr1, wr2, wr3, wr4;
  logic        ps_start;
  logic        ps_err_set;
  logic        ps_ovr_set;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign sel     = (csr.csr_a[13:10] == CSR_ADDR);
  assign reg_sel = csr.csr_a[2:0];
  assign wr0     = sel && csr.csr_we && (reg_sel == 3'd0);
  assign wr1     = sel && csr.csr_we && (reg_sel == 3'd1);
  assign wr2     = sel && csr.csr_we && (reg_sel == 3'd2);
  assign wr3     = sel && csr.csr_we && (reg_sel == 3'd3);
  assign wr4     = sel && csr.csr_we && (reg_sel == 3'd4);

  assign ps_start   = wr3 && csr.csr_di[19];
  assign ps_ovr_set = ps_start && (ps_state != PS_IDLE);
  assign ps_err_set = (ps_state == PS_WAIT) && !dqs_psdone && (ps_tmr == '0);

  assign unused_bits = ^{csr.csr_di[31:24], csr.csr_a[9:3]};

  // Phase-shift sequencer; psincdec only carries meaning alongside psen.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ps_state     <= PS_IDLE;
      ps_tmr       <= '0;
      ps_dir       <= 1'b0;
      ps_pos       <= '0;
      dqs_psen     <= 1'b0;
      dqs_psincdec <= 1'b0;
    end else begin
      dqs_psen     <= 1'b0;
      dqs_psincdec <= 1'b0;
      case (ps_state)
        PS_IDLE: begin
          if (ps_start) begin
            dqs_psen     <= 1'b1;
            dqs_psincdec <= csr.csr_di[20];
            ps_dir       <= csr.csr_di[20];
            ps_tmr       <= TMR_W'(PS_TIMEOUT - 1);
            ps_state     <= PS_WAIT;
          end
        end
        PS_WAIT: begin
          if (dqs_psdone) begin
            ps_pos   <= ps_dir ? ps_pos + 10'sd1 : ps_pos - 10'sd1;
            ps_state <= PS_IDLE;
          end else if (ps_tmr == '0) begin
            ps_state <= PS_IDLE;
          end else begin
            ps_tmr <= ps_tmr - 1'b1;
          end
        end
        default: ps_state <= PS_IDLE;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a clear takes priority.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ps_err <= 1'b0;
      ps_ovr <= 1'b0;
    end else begin
      if (ps_err_set)
        ps_err <= 1'b1;
      else if (wr4 && csr.csr_di[2])
        ps_err <= 1'b0;
      if (ps_ovr_set)
        ps_ovr <= 1'b1;
      else if (wr4 && csr.csr_di[1])
        ps_ovr <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pll_meta <= 2'b00;
      pll_sync <= 2'b00;
    end else begin
      pll_meta <= pll_stat;
      pll_sync <= pll_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bypass    <= 1'b1;
      sdram_rst <= 1'b1;
      sdram_cke <= 1'b0;
    end else if (wr0) begin
      bypass    <= csr.csr_di[0];
      sdram_rst <= csr.csr_di[1];
      sdram_cke <= csr.csr_di[2];
    end
  end

  // Command strobes are single-cycle; address and bank persist for readback.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sdram_cs_n  <= 1'b1;
      sdram_we_n  <= 1'b1;
      sdram_cas_n <= 1'b1;
      sdram_ras_n <= 1'b1;
      sdram_adr   <= '0;
      sdram_ba    <= '0;
    end else begin
      sdram_cs_n  <= 1'b1;
      sdram_we_n  <= 1'b1;
      sdram_cas_n <= 1'b1;
      sdram_ras_n <= 1'b1;
      if (wr1) begin
        sdram_cs_n  <= ~csr.csr_di[0];
        sdram_we_n  <= ~csr.csr_di[1];
        sdram_cas_n <= ~csr.csr_di[2];
        sdram_ras_n <= ~csr.csr_di[3];
        sdram_adr   <= csr.csr_di[4 +: ADR_W];
        sdram_ba    <= csr.csr_di[4 + ADR_W +: BA_W];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tim_rp   <= 3'd2;
      tim_rcd  <= 3'd2;
      tim_cas  <= 1'b0;
      tim_refi <= 11'd740;
      tim_rfc  <= 4'd8;
      tim_wr   <= 2'd2;
    end else if (wr2) begin
      tim_rp   <= csr.csr_di[2:0];
      tim_rcd  <= csr.csr_di[5:3];
      tim_cas  <= csr.csr_di[6];
      tim_refi <= csr.csr_di[17:7];
      tim_rfc  <= csr.csr_di[21:18];
      tim_wr   <= csr.csr_di[23:22];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idelay_rst <= '0;
      idelay_ce  <= '0;
      idelay_inc <= '0;
    end else if (wr3) begin
      idelay_rst <= csr.csr_di[LANES-1:0] & {LANES{csr.csr_di[16]}};
      idelay_ce  <= csr.csr_di[LANES-1:0] & {LANES{csr.csr_di[17]}};
      idelay_inc <= csr.csr_di[LANES-1:0] & {LANES{csr.csr_di[18]}};
    end else begin
      idelay_rst <= '0;
      idelay_ce  <= '0;
      idelay_inc <= '0;
    end
  end

  // Shadow of each lane's IDELAY tap; reset has priority over a step.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < LANES; i++)
        tap[i] <= '0;
    end else if (wr3) begin
      for (int i = 0; i < LANES; i++) begin
        if (csr.csr_di[i]) begin
          if (csr.csr_di[16])
            tap[i] <= '0;
          else if (csr.csr_di[17])
            tap[i] <= csr.csr_di[18] ? tap[i] + TAP_W'(1) : tap[i] - TAP_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      3'd0: rd_val[2:0] = {sdram_cke, sdram_rst, bypass};
      3'd1: begin
        rd_val[4 +: ADR_W]        = sdram_adr;
        rd_val[4 + ADR_W +: BA_W] = sdram_ba;
      end
      3'd2: rd_val[23:0] = {tim_wr, tim_rfc, tim_refi, tim_cas, tim_rcd, tim_rp};
      3'd4: begin
        rd_val[31:30] = pll_sync;
        rd_val[25:16] = ps_pos;
        rd_val[2:0]   = {ps_err, ps_ovr, ps_state == PS_WAIT};
      end
      3'd5: begin
        for (int i = 0; i < LANES; i++)
          rd_val[i*TAP_W +: TAP_W] = tap[i];
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      csr.csr_do <= '0;
    else
      csr.csr_do <= sel ? rd_val : '0;
  end

endmodule
